// File: rtl/gate_bist_engine.sv
// Built-in self-test engine for a 2-input combinational gate: steps {a,b} through 00..11,
// compares the gate output against EXPECT. Optional macro BIST_STOP_ON_FAIL_EN ends the run on the first mismatch.
module gate_bist_engine #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECT        = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       c_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [1:0] first_fail_vec,
    output logic       fail_valid
);

    // A zero settle time still needs one cycle for the registered vector to reach the gate.
    localparam int N  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    vec_reg, vec_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    fail_count_reg, fail_count_next;
    logic [1:0]    first_fail_reg, first_fail_next;
    logic          fail_valid_reg, fail_valid_next;
    logic          mismatch;

    assign mismatch = (c_in != EXPECT[vec_reg]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            vec_reg        <= 2'd0;
            cnt_reg        <= '0;
            fail_count_reg <= 3'd0;
            first_fail_reg <= 2'd0;
            fail_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vec_reg        <= vec_next;
            cnt_reg        <= cnt_next;
            fail_count_reg <= fail_count_next;
            first_fail_reg <= first_fail_next;
            fail_valid_reg <= fail_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        vec_next        = vec_reg;
        cnt_next        = cnt_reg;
        fail_count_next = fail_count_reg;
        first_fail_next = first_fail_reg;
        fail_valid_next = fail_valid_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next      = SETTLE;
                    vec_next        = 2'd0;
                    cnt_next        = '0;
                    fail_count_next = 3'd0;
                    first_fail_next = 2'd0;
                    fail_valid_next = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    // At most four vectors are checked, so the 3-bit count cannot wrap.
                    fail_count_next = fail_count_reg + 3'd1;
                    if (!fail_valid_reg) begin
                        first_fail_next = vec_reg;
                        fail_valid_next = 1'b1;
                    end
                end
`ifdef BIST_STOP_ON_FAIL_EN
                if (mismatch || vec_reg == 2'd3) begin
`else
                if (vec_reg == 2'd3) begin
`endif
                    state_next = DONE;
                end else begin
                    vec_next   = vec_reg + 2'd1;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign a_out          = vec_reg[1];
    assign b_out          = vec_reg[0];
    assign busy           = (state_reg == SETTLE) || (state_reg == CHECK);
    assign done           = (state_reg == DONE);
    assign pass           = done && (fail_count_reg == 3'd0);
    assign fail_count     = fail_count_reg;
    assign first_fail_vec = first_fail_reg;
    assign fail_valid     = fail_valid_reg;

endmodule

// File: tb/tb_gate_bist_engine.sv
// Directed bench for gate_bist_engine: a gate model on c_in selected by mode, table-driven runs
// plus hand sequences for start re-pulse, mid-run reset, rst/start collision and zero settle time.
module tb_gate_bist_engine;

    logic       clk = 1'b0;
    logic       rst, start, start0;
    logic       c_in, c_in0;
    logic       a_out, b_out, busy, done, pass, fail_valid;
    logic [2:0] fail_count;
    logic [1:0] first_fail_vec;
    logic       a_out0, b_out0, busy0, done0, pass0, fail_valid0;
    logic [2:0] fail_count0;
    logic [1:0] first_fail_vec0;
    int         mode, mode0;
    int         n_checks, n_fail;

    always #5 clk = ~clk;

    // 0 AND, 1 tied 0, 2 OR, 3 tied 1, 4 NAND
    function automatic logic gate(input int m, input logic a, input logic b);
        case (m)
            0:       return a & b;
            1:       return 1'b0;
            2:       return a | b;
            3:       return 1'b1;
            default: return ~(a & b);
        endcase
    endfunction

    assign c_in  = gate(mode, a_out, b_out);
    assign c_in0 = gate(mode0, a_out0, b_out0);

    gate_bist_engine dut (
        .clk(clk), .rst(rst), .start(start), .c_in(c_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_vec(first_fail_vec), .fail_valid(fail_valid)
    );

    gate_bist_engine #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .c_in(c_in0),
        .a_out(a_out0), .b_out(b_out0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_count(fail_count0), .first_fail_vec(first_fail_vec0), .fail_valid(fail_valid0)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start on the main DUT and return edges from E0 until done is seen (100 = timeout).
    task automatic run_main(input int m, output int cyc);
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    typedef struct {
        int mode;
        int done_cyc;
        int fc;
        int ffv;
        int fv;
        int pass;
    } vec_t;

    vec_t tbl[6];
    int   cyc;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        start0   = 1'b0;
        mode     = 0;
        mode0    = 0;

`ifdef BIST_STOP_ON_FAIL_EN
        tbl[0] = '{0, 12, 0, 0, 0, 1};
        tbl[1] = '{1, 12, 1, 3, 1, 0};
        tbl[2] = '{2,  6, 1, 1, 1, 0};
        tbl[3] = '{0, 12, 0, 0, 0, 1};
        tbl[4] = '{4,  3, 1, 0, 1, 0};
        tbl[5] = '{3,  3, 1, 0, 1, 0};
`else
        tbl[0] = '{0, 12, 0, 0, 0, 1};
        tbl[1] = '{1, 12, 1, 3, 1, 0};
        tbl[2] = '{2, 12, 2, 1, 1, 0};
        tbl[3] = '{0, 12, 0, 0, 0, 1};
        tbl[4] = '{4, 12, 4, 0, 1, 0};
        tbl[5] = '{3, 12, 3, 0, 1, 0};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_ab", int'({a_out, b_out}), 0);
        check("rst_fc", int'(fail_count), 0);
        check("rst_fv", int'(fail_valid), 0);
        check("rst_done0", int'(done0), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_main(tbl[i].mode, cyc);
            $display("run %0d mode %0d: cycles %0d fc %0d ffv %0d fv %0d pass %0d",
                     i, tbl[i].mode, cyc, fail_count, first_fail_vec, fail_valid, pass);
            check($sformatf("t%0d_done_cyc", i), cyc, tbl[i].done_cyc);
            check($sformatf("t%0d_fc", i), int'(fail_count), tbl[i].fc);
            check($sformatf("t%0d_ffv", i), int'(first_fail_vec), tbl[i].ffv);
            check($sformatf("t%0d_fv", i), int'(fail_valid), tbl[i].fv);
            check($sformatf("t%0d_pass", i), int'(pass), tbl[i].pass);
            check($sformatf("t%0d_busy", i), int'(busy), 0);
        end

        // AND gate, vector stepping every 3 cycles, start re-pulsed at edges E0+4 and E0+8
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            check($sformatf("step%0d_ab", k), int'({a_out, b_out}), (k < 12) ? k / 3 : 3);
            check($sformatf("step%0d_busy", k), int'(busy), (k < 12) ? 1 : 0);
            check($sformatf("step%0d_done", k), int'(done), (k == 12) ? 1 : 0);
            start = (k == 3 || k == 7);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("repulse_pass", int'(pass), 1);
        $display("repulse run: done %0d pass %0d", done, pass);

        // tied 1, reset during the third vector
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_ab", int'({a_out, b_out}), 0);
        check("midrst_fc", int'(fail_count), 0);
        check("midrst_fv", int'(fail_valid), 0);
        check("midrst_ffv", int'(first_fail_vec), 0);
        $display("mid-run reset: busy %0d done %0d fc %0d", busy, done, fail_count);
        @(negedge clk);
        rst = 1'b0;
        run_main(3, cyc);
        $display("after reset run: cycles %0d fc %0d ffv %0d", cyc, fail_count, first_fail_vec);
        check("rerun_cyc", cyc, tbl[5].done_cyc);
        check("rerun_fc", int'(fail_count), tbl[5].fc);
        check("rerun_ffv", int'(first_fail_vec), 0);
        check("rerun_pass", int'(pass), 0);

        // rst and start together from DONE: reset wins
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("collide_busy", int'(busy), 0);
        check("collide_done", int'(done), 0);
        check("collide_fc", int'(fail_count), 0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("collide_idle", int'(busy), 0);
        $display("rst+start collision: busy %0d done %0d", busy, done);

        // SETTLE_CYCLES = 0 behaves as 1: done after 8 cycles
        mode0 = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        $display("settle0 run: cycles %0d pass %0d", cyc, pass0);
        check("s0_done_cyc", cyc, 8);
        check("s0_pass", int'(pass0), 1);
        check("s0_ab", int'({a_out0, b_out0}), 3);
        check("s0_fv", int'(fail_valid0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
